// File: rtl/vga_pkg.sv
// vga_pkg: shot detector defaults and VGA timing constants
package vga_pkg;
  localparam int DEF_HIT_RADIUS = 3;
  localparam int DEF_HIT_THRESHOLD = 4;
  localparam int CNT_MAX = 127;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int H_TOTAL = 1056;
  localparam int V_TOTAL = 628;
endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing and pixel stream bundle
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic vsync;
  logic vblnk;
  logic hsync;
  logic hblnk;
  logic [11:0] rgb;
  modport in (input vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
  modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/shot_window_cmp.sv
// shot_window_cmp: visible pixel inside the sampling window with target colour
module shot_window_cmp (
  input logic [10:0] hcount,
  input logic [10:0] vcount,
  input logic hblnk,
  input logic vblnk,
  input logic [11:0] rgb,
  input logic [11:0] target_rgb,
  input logic [12:0] x_lo,
  input logic [12:0] x_hi,
  input logic [12:0] y_lo,
  input logic [12:0] y_hi,
  output logic match
);
  assign match = !hblnk && !vblnk && rgb == target_rgb &&
                 {2'b0, hcount} >= x_lo && {2'b0, hcount} <= x_hi &&
                 {2'b0, vcount} >= y_lo && {2'b0, vcount} <= y_hi;
endmodule

// File: rtl/shot_detect.sv
// shot_detect: counts target-coloured pixels around a clicked cursor over one frame
module shot_detect
  import vga_pkg::*;
#(
  parameter int HIT_RADIUS = DEF_HIT_RADIUS,
  parameter int HIT_THRESHOLD = DEF_HIT_THRESHOLD
) (
  input logic clk,
  input logic rst,
  input logic [11:0] xpos,
  input logic [11:0] ypos,
  input logic click,
  input logic [11:0] target_rgb,
  vga_if.in in,
  output logic busy,
  output logic result_valid,
  output logic hit,
  output logic [6:0] match_count
);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SCAN, REPORT} state_t;
  localparam logic [12:0] RAD = 13'(HIT_RADIUS);
  localparam logic [6:0] THR = 7'(HIT_THRESHOLD);
  localparam logic [6:0] SAT = 7'(CNT_MAX);
  state_t state, state_nx;
  logic [12:0] x_lo, x_hi, y_lo, y_hi;
  logic [6:0] cnt;
  logic match, frame_start, scan_end, accept;
  assign accept = state == IDLE && click;
  assign frame_start = in.vcount == '0 && in.hcount == '0;
  assign scan_end = {2'b0, in.vcount} > y_hi || in.vblnk;
  shot_window_cmp u_cmp (
    .hcount(in.hcount),
    .vcount(in.vcount),
    .hblnk(in.hblnk),
    .vblnk(in.vblnk),
    .rgb(in.rgb),
    .target_rgb(target_rgb),
    .x_lo(x_lo),
    .x_hi(x_hi),
    .y_lo(y_lo),
    .y_hi(y_hi),
    .match(match)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (click ? WAIT_FRAME : IDLE) :
               state == WAIT_FRAME ? (frame_start ? SCAN : WAIT_FRAME) :
               state == SCAN ? (scan_end ? REPORT : SCAN) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      x_lo <= '0;
      x_hi <= '0;
      y_lo <= '0;
      y_hi <= '0;
    end else if (accept) begin
      x_lo <= {1'b0, xpos} >= RAD ? {1'b0, xpos} - RAD : '0;
      x_hi <= {1'b0, xpos} + RAD;
      y_lo <= {1'b0, ypos} >= RAD ? {1'b0, ypos} - RAD : '0;
      y_hi <= {1'b0, ypos} + RAD;
    end
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (state == WAIT_FRAME && frame_start) cnt <= {6'b0, match};
    else if (state == SCAN && !scan_end && match && cnt != SAT) cnt <= cnt + 7'd1;
  always_ff @(posedge clk)
    if (rst) begin
      busy <= 1'b0;
      result_valid <= 1'b0;
      hit <= 1'b0;
      match_count <= '0;
    end else begin
      busy <= state_nx == WAIT_FRAME || state_nx == SCAN;
      result_valid <= state_nx == REPORT;
      if (state_nx == REPORT) begin
        hit <= cnt >= THR;
        match_count <= cnt;
      end
    end
endmodule

// File: tb/tb_shot_detect.sv
// tb_shot_detect: sparse-raster random and directed check of shot_detect against a frame model
module tb_shot_detect;
  import vga_pkg::*;
  logic clk = 0, rst = 1, click = 0, busy, result_valid, hit;
  logic [11:0] xpos = 0, ypos = 0, target_rgb = 12'h0F0;
  logic [6:0] match_count;
  int n_vec = 0, n_err = 0;
  int rows[$], cols[$];
  logic [11:0] img [int];
  bit m_busy, m_rv, m_hit, waiting, started;
  int m_cnt, acc, xl, xh, yl, yh;
  vga_if vif();
  shot_detect dut (
    .clk(clk),
    .rst(rst),
    .xpos(xpos),
    .ypos(ypos),
    .click(click),
    .target_rgb(target_rgb),
    .in(vif),
    .busy(busy),
    .result_valid(result_valid),
    .hit(hit),
    .match_count(match_count)
  );
  always #5 clk = ~clk;
  function automatic int key(int v, int h);
    return v * 4096 + h;
  endfunction
  function automatic logic [11:0] pix(int v, int h);
    return img.exists(key(v, h)) ? img[key(v, h)] : 12'h000;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic set_block(input int x0, input int y0, input int n);
    for (int dy = 0; dy < n; dy++)
      for (int dx = 0; dx < n; dx++) img[key(y0 + dy, x0 + dx)] = 12'h0F0;
  endtask
  task automatic do_click(input int x, input int y);
    @(posedge clk); #1;
    xpos = 12'(x);
    ypos = 12'(y);
    click = 1;
    @(posedge clk); #1;
    click = 0;
  endtask
  task automatic expect_result(input string name, input int cnt, input bit h);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (result_valid !== 1'b1 && k < 2700);
    chk({name, " result_valid"}, result_valid, 1);
    chk({name, " match_count"}, match_count, cnt);
    chk({name, " hit"}, hit, h);
    chk({name, " busy"}, busy, 0);
    chk({name, " model count"}, m_cnt, cnt);
  endtask
  // Sparse raster: only rows/columns near the regions of interest are emitted, blanking carries target colour
  initial begin
    for (int i = 0; i < 8; i++) begin rows.push_back(i); cols.push_back(i); end
    for (int i = 195; i <= 205; i++) rows.push_back(i);
    for (int i = 295; i <= 305; i++) rows.push_back(i);
    for (int i = 595; i <= 601; i++) rows.push_back(i);
    for (int i = 95; i <= 105; i++) cols.push_back(i);
    for (int i = 395; i <= 405; i++) cols.push_back(i);
    for (int i = 795; i <= 800; i++) cols.push_back(i);
    vif.vcount = 11'(V_ACTIVE);
    vif.hcount = 11'(H_ACTIVE);
    vif.vblnk = 1;
    vif.hblnk = 1;
    vif.vsync = 0;
    vif.hsync = 0;
    vif.rgb = 0;
    forever foreach (rows[r]) foreach (cols[c]) begin
      @(posedge clk); #1;
      vif.vcount = 11'(rows[r]);
      vif.hcount = 11'(cols[c]);
      vif.vblnk = rows[r] >= V_ACTIVE;
      vif.hblnk = cols[c] >= H_ACTIVE;
      vif.vsync = rows[r] == V_ACTIVE + 1;
      vif.hsync = cols[c] == H_ACTIVE;
      vif.rgb = (rows[r] >= V_ACTIVE || cols[c] >= H_ACTIVE) ? target_rgb : pix(rows[r], cols[c]);
    end
  end
  // Reference: the first frame starting after an accepted click is summed over the clamped window
  always @(negedge clk) begin : model
    int v, h;
    bit mt;
    if (started) begin
      chk("busy", busy, m_busy);
      chk("result_valid", result_valid, m_rv);
      chk("match_count", match_count, m_cnt);
      chk("hit", hit, m_hit);
    end
    started = 1;
    v = vif.vcount;
    h = vif.hcount;
    mt = !vif.vblnk && !vif.hblnk && h >= xl && h <= xh && v >= yl && v <= yh && vif.rgb == target_rgb;
    if (rst) begin
      m_busy = 0; m_rv = 0; m_hit = 0; m_cnt = 0; waiting = 0;
      xl = 0; xh = 0; yl = 0; yh = 0;
    end else if (m_rv) m_rv = 0;
    else if (!m_busy) begin
      if (click) begin
        m_busy = 1;
        waiting = 1;
        xl = xpos >= DEF_HIT_RADIUS ? int'(xpos) - DEF_HIT_RADIUS : 0;
        xh = int'(xpos) + DEF_HIT_RADIUS;
        yl = ypos >= DEF_HIT_RADIUS ? int'(ypos) - DEF_HIT_RADIUS : 0;
        yh = int'(ypos) + DEF_HIT_RADIUS;
      end
    end else if (waiting) begin
      if (v == 0 && h == 0) begin waiting = 0; acc = mt; end
    end else if (v > yh || vif.vblnk) begin
      m_rv = 1; m_busy = 0; m_cnt = acc; m_hit = acc >= DEF_HIT_THRESHOLD;
    end else if (mt) acc = acc < CNT_MAX ? acc + 1 : CNT_MAX;
  end
  initial begin
    int k, n, x, y, mode;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset result_valid", result_valid, 0);
    chk("reset hit", hit, 0);
    chk("reset match_count", match_count, 0);
    @(posedge clk); #1;
    rst = 0;
    set_block(97, 197, 7);
    do_click(100, 200);
    expect_result("centre_block", 49, 1);
    click = 1;
    xpos = 100;
    ypos = 200;
    @(posedge clk); #1;
    click = 0;
    @(negedge clk);
    chk("report click result_valid", result_valid, 0);
    chk("report click busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("report click still idle", busy, 0);
    do_click(400, 300);
    expect_result("miss", 0, 0);
    img.delete();
    set_block(0, 0, 5);
    img[key(5, 2)] = 12'h0F0;
    img[key(2, 5)] = 12'h0F0;
    do_click(1, 1);
    expect_result("corner_clamp", 25, 1);
    img.delete();
    img[key(197, 97)] = 12'h0F0;
    img[key(203, 103)] = 12'h0F0;
    img[key(200, 100)] = 12'h0F0;
    img[key(200, 104)] = 12'h0F0;
    img[key(196, 100)] = 12'h0F0;
    do_click(100, 200);
    expect_result("three_px", 3, 0);
    img[key(203, 97)] = 12'h0F0;
    do_click(100, 200);
    expect_result("four_px", 4, 1);
    img.delete();
    img[key(597, 798)] = 12'h0F0;
    do_click(798, 598);
    expect_result("blank_edge", 1, 0);
    img.delete();
    set_block(97, 197, 7);
    k = 0;
    do begin @(negedge clk); k++; end while (vif.vcount != V_ACTIVE && k < 2000);
    do_click(100, 200);
    k = 0;
    do begin @(negedge clk); k++; end while (busy !== 1'b1 && k < 10);
    chk("abort busy", busy, 1);
    do_click(400, 300);
    k = 0;
    do begin @(negedge clk); k++; end while (!(vif.vcount == 0 && vif.hcount == 0) && k < 2000);
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("abort busy after rst", busy, 0);
    n = 0;
    repeat (2700) begin @(negedge clk); if (result_valid) n++; end
    chk("abort no result", n, 0);
    do_click(100, 200);
    expect_result("after_abort", 49, 1);
    for (int i = 0; i < 20; i++) begin
      target_rgb = $urandom_range(0, 3) == 0 ? 12'($urandom) : 12'h0F0;
      img.delete();
      foreach (rows[r]) foreach (cols[c])
        if (rows[r] < V_ACTIVE && cols[c] < H_ACTIVE && $urandom_range(0, 1) == 1)
          img[key(rows[r], cols[c])] = target_rgb;
      x = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 4095)) :
          cols[$urandom_range(0, cols.size() - 1)] + int'($urandom_range(0, 6)) - 3;
      y = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 4095)) :
          rows[$urandom_range(0, rows.size() - 1)] + int'($urandom_range(0, 6)) - 3;
      do_click(x < 0 ? 0 : x, y < 0 ? 0 : y);
      mode = $urandom_range(0, 5);
      if (mode == 0) begin
        repeat ($urandom_range(1, 2000)) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
      end else begin
        k = 0;
        do begin @(negedge clk); k++; end while (result_valid !== 1'b1 && k < 2700);
        chk("random result_valid", result_valid, 1);
        if (mode == 1) click = 1;
        @(posedge clk); #1;
        click = 0;
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
